// File: rtl/wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int STAT_W     = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One buffered mul/div result; live drops when a newer pipeline write
    // to the same register makes the result stale.
    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } md_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PIPE,
        GRANT_MD
    } grant_e;

    typedef enum logic {
        ARB_RUN,
        ARB_STALL
    } arb_state_e;

    // Saturating add used by the optional statistics counters.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: pipeline request, mul/div handshake, register-file
// write port, stall and error flags.
// WB_STATS_EN adds the stall/kill statistics outputs.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic                  WB_pipe_valid;
    logic [REG_ADDR_W-1:0] WB_pipe_rd;
    logic                  WB_pipe_memtoreg;
    logic [DATA_W-1:0]     WB_pipe_alu_result;
    logic [DATA_W-1:0]     WB_pipe_mem_data;

    logic                  WB_md_valid;
    logic                  WB_md_ready;
    logic [REG_ADDR_W-1:0] WB_md_rd;
    logic [DATA_W-1:0]     WB_md_data;

    logic [REG_ADDR_W-1:0] WB_address_wr;
    logic                  WB_write_1;
    logic [DATA_W-1:0]     WB_data_wb_out1;
    logic                  WB_stall;
    logic                  WB_err;
`ifdef WB_STATS_EN
    logic [STAT_W-1:0]     WB_stat_stall;
    logic [STAT_W-1:0]     WB_stat_kill;
`endif

    // Arbiter side.
    modport slave (
        input  WB_pipe_valid, WB_pipe_rd, WB_pipe_memtoreg,
               WB_pipe_alu_result, WB_pipe_mem_data,
               WB_md_valid, WB_md_rd, WB_md_data,
        output WB_md_ready, WB_address_wr, WB_write_1, WB_data_wb_out1,
               WB_stall, WB_err
`ifdef WB_STATS_EN
        , output WB_stat_stall, WB_stat_kill
`endif
    );

    // Pipeline / mul-div / register-file side.
    modport master (
        output WB_pipe_valid, WB_pipe_rd, WB_pipe_memtoreg,
               WB_pipe_alu_result, WB_pipe_mem_data,
               WB_md_valid, WB_md_rd, WB_md_data,
        input  WB_md_ready, WB_address_wr, WB_write_1, WB_data_wb_out1,
               WB_stall, WB_err
`ifdef WB_STATS_EN
        , input WB_stat_stall, WB_stat_kill
`endif
    );

endinterface

// File: rtl/wb_md_fifo.sv
// Mul/div result buffer: FIFO storage with a live bit per entry and a
// parallel rd compare that kills stale entries on a pipeline write.
// WB_STATS_EN adds the kill_num output (entries killed this cycle).
module wb_md_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_en,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop_en,
    input  logic                  kill_en,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output md_entry_t             head,
    output logic                  full,
    output logic                  empty
`ifdef WB_STATS_EN
    , output logic [CNT_W-1:0]    kill_num
`endif
);

    md_entry_t        entries_q [DEPTH];
    md_entry_t        entries_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] kill_mask;
    logic             do_push, do_pop;

    // Free slots always hold live=0, so the compare never hits them.
    always_comb begin
        kill_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_mask[i] = kill_en && entries_q[i].live && (entries_q[i].rd == kill_rd);
        end
    end

    // Kill, pop and push next-state; a same-cycle push lands after the kill
    // so the newer result survives.
    always_comb begin
        do_push   = push_en && !full;
        do_pop    = pop_en && !empty;
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_mask[i]) begin
                entries_d[i].live = 1'b0;
            end
        end
        if (do_pop) begin
            entries_d[rd_ptr_q].live = 1'b0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            entries_d[wr_ptr_q].live = 1'b1;
            entries_d[wr_ptr_q].rd   = push_rd;
            entries_d[wr_ptr_q].data = push_data;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head  = entries_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

`ifdef WB_STATS_EN
    assign kill_num = CNT_W'($countones(kill_mask));
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges the in-order pipeline and the
// buffered mul/div results onto one write port. Pipeline has priority; a
// starvation counter forces a stall so a live buffered result drains.
// WB_STATS_EN adds saturating stall-cycle and killed-entry counters.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ARB_RUN   | normal priority: pipeline first, buffer head when idle
// ARB_STALL | WB_stall high; buffer head owns the port until it pops
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int MD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic         SYS_clk,
    input logic         SYS_reset,
    wb_arbiter_if.slave bus
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e            state_q, state_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  write_q, write_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  err_q, err_d;

    grant_e                grant;
    md_entry_t             head;
    logic                  fifo_full, fifo_empty;
    logic                  pipe_live, pipe_write, head_live, pop, push;
    logic [DATA_W-1:0]     pipe_data;

`ifdef WB_STATS_EN
    localparam int KILL_W = $clog2(MD_DEPTH + 1);
    logic [KILL_W-1:0] kill_num;
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;
    logic [STAT_W-1:0] stat_kill_q, stat_kill_d;

    wb_md_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
        .clk       (SYS_clk),
        .rst       (SYS_reset),
        .push_en   (push),
        .push_rd   (bus.WB_md_rd),
        .push_data (bus.WB_md_data),
        .pop_en    (pop),
        .kill_en   (pipe_write),
        .kill_rd   (bus.WB_pipe_rd),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .kill_num  (kill_num)
    );

    // Saturating statistics next-state.
    always_comb begin
        stat_stall_d = (state_q == ARB_STALL) ? sat_add(stat_stall_q, STAT_W'(1)) : stat_stall_q;
        stat_kill_d  = sat_add(stat_kill_q, STAT_W'(kill_num));
    end

    // Statistics registers.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            stat_stall_q <= '0;
            stat_kill_q  <= '0;
        end else begin
            stat_stall_q <= stat_stall_d;
            stat_kill_q  <= stat_kill_d;
        end
    end

    assign bus.WB_stat_stall = stat_stall_q;
    assign bus.WB_stat_kill  = stat_kill_q;
`else
    wb_md_fifo #(.DEPTH(MD_DEPTH)) u_fifo (
        .clk       (SYS_clk),
        .rst       (SYS_reset),
        .push_en   (push),
        .push_rd   (bus.WB_md_rd),
        .push_data (bus.WB_md_data),
        .pop_en    (pop),
        .kill_en   (pipe_write),
        .kill_rd   (bus.WB_pipe_rd),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`endif

    // Port arbitration; under stall any pipeline request still wins (and is
    // flagged as an error), otherwise rd=0 requests count as idle.
    always_comb begin
        pipe_live = bus.WB_pipe_valid && (bus.WB_pipe_rd != REG_ZERO);
        pipe_data = bus.WB_pipe_memtoreg ? bus.WB_pipe_mem_data : bus.WB_pipe_alu_result;
        head_live = !fifo_empty && head.live;
        grant     = GRANT_NONE;
        if (state_q == ARB_STALL) begin
            if (bus.WB_pipe_valid) begin
                grant = GRANT_PIPE;
            end else if (!fifo_empty) begin
                grant = GRANT_MD;
            end
        end else if (pipe_live) begin
            grant = GRANT_PIPE;
        end else if (!fifo_empty) begin
            grant = GRANT_MD;
        end
        pipe_write = (grant == GRANT_PIPE) && pipe_live;
        pop        = (grant == GRANT_MD);
        push       = bus.WB_md_valid && !fifo_full && (bus.WB_md_rd != REG_ZERO);
    end

    // Starvation counter and stall state next-state.
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if ((grant == GRANT_PIPE) && head_live &&
                     (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        case (state_q)
            ARB_RUN: begin
                if (starve_d == STARVE_W'(STARVE_LIMIT)) begin
                    state_d = ARB_STALL;
                end
            end
            ARB_STALL: begin
                if (pop || fifo_empty) begin
                    state_d = ARB_RUN;
                end
            end
            default: state_d = ARB_RUN;
        endcase
    end

    // Write-port and error next-state; port fields read zero when idle.
    always_comb begin
        write_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        if (pipe_write) begin
            write_d = 1'b1;
            addr_d  = bus.WB_pipe_rd;
            data_d  = pipe_data;
        end else if (pop && head.live) begin
            write_d = 1'b1;
            addr_d  = head.rd;
            data_d  = head.data;
        end
        err_d = err_q || ((state_q == ARB_STALL) && bus.WB_pipe_valid);
    end

    // State, counter and output registers.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q  <= ARB_RUN;
            starve_q <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign bus.WB_md_ready     = !fifo_full;
    assign bus.WB_address_wr   = addr_q;
    assign bus.WB_write_1      = write_q;
    assign bus.WB_data_wb_out1 = data_q;
    assign bus.WB_stall        = (state_q == ARB_STALL);
    assign bus.WB_err          = err_q;

endmodule
